// File: rtl/sync_rom_seq_player.sv
// Pattern-sequence player over a banked one-hot ROM with a start/step/abort handshake.
//
// Ports:
//   clock, reset_n  - rising-edge clock and asynchronous active-low reset.
//   start           - begin playback; accepted only while idle.
//   abort           - drop the sequence and return to idle; wins over start and step.
//   step            - advance to the next entry; accepted only while data_valid is high.
//   bank_sel        - bank to play, latched on start.
//   last_index      - final entry to play, latched on start.
//   data_out        - registered ROM word for the entry at index.
//   index           - entry currently shown.
//   data_valid      - data_out holds the entry at index.
//   busy            - the player is not idle.
//   done            - one-cycle pulse at the end of the sequence.
//
// Build option:
//   SEQ_ROM_LOOP_EN - a step on the last entry pulses done and restarts from entry 0.
//                     Playback then runs until abort. Undefined: playback stops after the last entry.
module sync_rom_seq_player #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int BANK_WIDTH = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  step,
    input  logic [BANK_WIDTH-1:0] bank_sel,
    input  logic [ADDR_WIDTH-1:0] last_index,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] index,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DONE
    } state_t;

    state_t                  state_q;
    logic [BANK_WIDTH-1:0]   bank_q;
    logic [ADDR_WIDTH-1:0]   last_q;
    logic [ADDR_WIDTH-1:0]   index_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    valid_q;
    logic                    busy_q;
    logic                    done_q;

    logic [DATA_WIDTH-1:0]   rom_d;
    logic [3:0]              rom_a;
    int unsigned             pos;

    // Bank 0 bit position for each of the 16 base entries.
    function automatic logic [1:0] p0_of(input logic [3:0] i);
        logic [1:0] p;
        unique case (i)
            4'd0:  p = 2'd0;
            4'd1:  p = 2'd2;
            4'd2:  p = 2'd1;
            4'd3:  p = 2'd3;
            4'd4:  p = 2'd0;
            4'd5:  p = 2'd2;
            4'd6:  p = 2'd1;
            4'd7:  p = 2'd3;
            4'd8:  p = 2'd0;
            4'd9:  p = 2'd0;
            4'd10: p = 2'd3;
            4'd11: p = 2'd3;
            4'd12: p = 2'd1;
            4'd13: p = 2'd2;
            4'd14: p = 2'd2;
            4'd15: p = 2'd0;
        endcase
        return p;
    endfunction

    // The contents repeat every 16 entries.
    // Each further bank rotates the one-hot bit up by one position.
    always_comb begin
        rom_a = 4'(index_q);
        pos   = (32'(p0_of(rom_a)) + 32'(bank_q)) % 32'(DATA_WIDTH);
        rom_d = DATA_WIDTH'(1) << pos;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            bank_q  <= '0;
            last_q  <= '0;
            index_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort && state_q != IDLE) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        // An abort in the same cycle suppresses start.
                        if (start && !abort) begin
                            bank_q  <= bank_sel;
                            last_q  <= last_index;
                            index_q <= '0;
                            busy_q  <= 1'b1;
                            state_q <= FETCH;
                        end
                    end
                    FETCH: begin
                        data_q  <= rom_d;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                    HOLD: begin
                        if (step) begin
                            valid_q <= 1'b0;
                            if (index_q != last_q) begin
                                index_q <= index_q + 1'b1;
                                state_q <= FETCH;
                            end else begin
                                done_q  <= 1'b1;
`ifdef SEQ_ROM_LOOP_EN
                                index_q <= '0;
                                state_q <= FETCH;
`else
                                state_q <= DONE;
`endif
                            end
                        end
                    end
                    DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign data_out   = data_q;
    assign index      = index_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sync_rom_seq_player.sv
// Self-checking bench for sync_rom_seq_player.
// Table-driven playbacks, a data scoreboard, and hand-written abort, reset and loop cases.
module tb_sync_rom_seq_player;

    localparam int DW = 4;
    localparam int AW = 4;
    localparam int BW = 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          step = 1'b0;
    logic [BW-1:0] bank_sel = '0;
    logic [AW-1:0] last_index = '0;
    logic [DW-1:0] data_out;
    logic [AW-1:0] index;
    logic          data_valid;
    logic          busy;
    logic          done;

    sync_rom_seq_player #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .BANK_WIDTH(BW)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .step       (step),
        .bank_sel   (bank_sel),
        .last_index (last_index),
        .data_out   (data_out),
        .index      (index),
        .data_valid (data_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] bank;
        logic [3:0] last;
        int         abort_at;
        logic [3:0] exp_first;
        int         exp_done;
    } vec_t;

    int            chk_cnt = 0;
    int            pass_cnt = 0;
    int            done_seen = 0;
    logic          prev_valid = 1'b0;
    logic [DW-1:0] exp_q[$];
    int            pos_tab[16] = '{0, 2, 1, 3, 0, 2, 1, 3, 0, 0, 3, 3, 1, 2, 2, 0};
    logic [3:0]    exp_b0[16] = '{4'b0001, 4'b0100, 4'b0010, 4'b1000,
                                  4'b0001, 4'b0100, 4'b0010, 4'b1000,
                                  4'b0001, 4'b0001, 4'b1000, 4'b1000,
                                  4'b0010, 4'b0100, 4'b0100, 4'b0001};

    function automatic logic [DW-1:0] model(int b, int i);
        int p;
        p = (pos_tab[i % 16] + b) % DW;
        return DW'(1) << p;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (data_valid !== 1'b1 && n < 6) begin
            tick();
            n++;
        end
    endtask

    // Scoreboard: one expected word per entry, popped on each data_valid rise.
    always @(posedge clock) begin
        #2;
        if (done === 1'b1) done_seen++;
        if (data_valid === 1'b1 && prev_valid !== 1'b1) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL sb_underflow: got data_out %0h with nothing expected", data_out);
            end else begin
                chk("sb_data", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
        prev_valid = data_valid;
    end

    task automatic run_vec(input vec_t v);
        int n;
        logic [DW-1:0] held;
        done_seen = 0;
        bank_sel = v.bank;
        last_index = v.last;
        start = 1'b1;
        exp_q.push_back(model(v.bank, 0));
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
        chk("valid_in_fetch", 32'(data_valid), 0);
        for (int i = 0; i <= int'(v.last); i++) begin
            wait_valid(n);
            chk("valid_latency", n, 1);
            chk("index", 32'(index), i);
            if (i == 0) chk("first_word", 32'(data_out), 32'(v.exp_first));
            if (v.bank == 2'd0) chk("bank0_word", 32'(data_out), 32'(exp_b0[i]));
            if (i == v.abort_at) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                chk("abort_busy", 32'(busy), 0);
                chk("abort_valid", 32'(data_valid), 0);
                repeat (3) tick();
                break;
            end
            // Stall one cycle while disturbing bank, last and start.
            held = data_out;
            bank_sel = ~v.bank;
            last_index = ~v.last;
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("hold_data", 32'(data_out), 32'(held));
            chk("hold_index", 32'(index), i);
            step = 1'b1;
            if (i < int'(v.last)) exp_q.push_back(model(v.bank, i + 1));
            tick();
            step = 1'b0;
            if (i == int'(v.last)) begin
                chk("done_pulse", 32'(done), 1);
                chk("busy_in_done", 32'(busy), 1);
                tick();
                chk("done_low", 32'(done), 0);
                chk("idle_busy", 32'(busy), 0);
                chk("idle_data", 32'(data_out), 32'(model(v.bank, int'(v.last))));
                chk("idle_index", 32'(index), 32'(v.last));
            end
        end
        tick();
        chk("done_count", done_seen, v.exp_done);
        chk("sb_drained", 32'(exp_q.size()), 0);
        exp_q.delete();
        bank_sel = '0;
        last_index = '0;
    endtask

`ifdef SEQ_ROM_LOOP_EN
    logic [3:0] loop_exp[4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
`endif

    initial begin
        vec_t vecs[6];
        int n;
        vecs[0] = '{2'd0, 4'd15, -1, 4'b0001, 1};
        vecs[1] = '{2'd1, 4'd0, -1, 4'b0010, 1};
        vecs[2] = '{2'd2, 4'd7, -1, 4'b0100, 1};
        vecs[3] = '{2'd3, 4'd15, -1, 4'b1000, 1};
        vecs[4] = '{2'd0, 4'd3, 2, 4'b0001, 0};
        vecs[5] = '{2'd3, 4'd5, 0, 4'b1000, 0};

        #12;
        chk("rst_data", 32'(data_out), 0);
        chk("rst_index", 32'(index), 0);
        chk("rst_valid", 32'(data_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_data", 32'(data_out), 0);
        chk("post_rst_done", 32'(done), 0);

        // Abort together with start keeps the player idle.
        abort = 1'b1;
        start = 1'b1;
        tick();
        chk("abort_start_busy", 32'(busy), 0);
        abort = 1'b0;
        start = 1'b0;
        tick();
        chk("abort_start_busy2", 32'(busy), 0);

`ifndef SEQ_ROM_LOOP_EN
        for (int k = 0; k < 6; k++) run_vec(vecs[k]);
`else
        done_seen = 0;
        bank_sel = 2'd0;
        last_index = 4'd1;
        start = 1'b1;
        exp_q.push_back(model(0, 0));
        tick();
        start = 1'b0;
        for (int s = 0; s < 4; s++) begin
            wait_valid(n);
            chk("loop_latency", n, 1);
            chk("loop_word", 32'(data_out), 32'(loop_exp[s]));
            step = 1'b1;
            exp_q.push_back(model(0, (s + 1) % 2));
            tick();
            step = 1'b0;
            chk("loop_done", 32'(done), (s % 2 == 1) ? 1 : 0);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_q.delete();
        chk("loop_abort_busy", 32'(busy), 0);
        chk("loop_done_count", done_seen, 2);
`endif

        // Abort while the first word is being fetched.
        done_seen = 0;
        bank_sel = 2'd2;
        last_index = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("fetch_abort_busy", 32'(busy), 0);
        repeat (3) tick();
        chk("fetch_abort_valid", 32'(data_valid), 0);
        chk("fetch_abort_done", done_seen, 0);

        // Reset in the middle of playback.
        done_seen = 0;
        bank_sel = 2'd1;
        last_index = 4'd2;
        start = 1'b1;
        exp_q.push_back(model(1, 0));
        tick();
        start = 1'b0;
        wait_valid(n);
        chk("mid_rst_latency", n, 1);
        step = 1'b1;
        exp_q.push_back(model(1, 1));
        tick();
        step = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_data", 32'(data_out), 0);
        chk("mid_rst_index", 32'(index), 0);
        chk("mid_rst_valid", 32'(data_valid), 0);
        exp_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) tick();
        chk("mid_rst_no_done", done_seen, 0);
        chk("mid_rst_idle", 32'(busy), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
